// File: rtl/div32by16_seq_if.sv
// Request/result bundle for the 32-by-16 sequential divider.
// The requester drives start/a/b; the divider returns q/r/err with busy/done status.
interface div32by16_seq_if;
    logic        start;
    logic [31:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        output start, a, b,
        input  q, r, busy, done, err
    );

    modport slave (
        input  start, a, b,
        output q, r, busy, done, err
    );
endinterface

// File: rtl/div32by16_seq.sv
// Sequential restoring divider: 32-bit dividend by 16-bit divisor, one quotient bit per clock.
// Overflow and divide-by-zero are flagged up front and finish in a single cycle.
module div32by16_seq (
    input  logic           clk,
    input  logic           rst,
    div32by16_seq_if.slave bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] quo_q, quo_d;
    logic [15:0] rmd_q, rmd_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    // Iteration datapath: partial remainder, dividend/quotient shifter, latched divisor.
    logic [15:0] rem_q, rem_d;
    logic [15:0] dvd_q, dvd_d;
    logic [15:0] div_q, div_d;

    logic [16:0] trial;
    logic        fits;
    logic [15:0] rem_step;
    logic [15:0] dvd_step;
    logic        reject;

    // R < b keeps trial - b below 2^16, so a 16-bit difference is exact.
    assign trial    = {rem_q, dvd_q[15]};
    assign fits     = trial >= {1'b0, div_q};
    assign rem_step = fits ? (trial[15:0] - div_q) : trial[15:0];
    assign dvd_step = {dvd_q[14:0], fits};
    assign reject   = (bus.b == 16'd0) || (bus.a[31:16] >= bus.b);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned and infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        div_d   = div_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    div_d  = bus.b;
                    err_d  = 1'b0;
                    busy_d = 1'b1;
                    if (reject) begin
                        quo_d   = 16'hFFFF;
                        rmd_d   = 16'h0000;
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        rem_d   = bus.a[31:16];
                        dvd_d   = bus.a[15:0];
                        cnt_d   = 4'd15;
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                rem_d = rem_step;
                dvd_d = dvd_step;
                if (cnt_q == 4'd0) begin
                    quo_d   = dvd_step;
                    rmd_d   = rem_step;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            quo_q   <= 16'd0;
            rmd_q   <= 16'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // NOTE: the iteration datapath is deliberately unreset; it is always loaded on accept before being read.
    always_ff @(posedge clk) begin
        rem_q <= rem_d;
        dvd_q <= dvd_d;
        div_q <= div_d;
    end

    assign bus.q    = quo_q;
    assign bus.r    = rmd_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.err  = err_q;
endmodule

// File: doc/div32by16_seq.md
# div32by16_seq

- Sequential restoring divider: the inverse of the team's 16x16 Vedic multiplier datapath.
- Splits a 32-bit dividend (e.g. a 32-bit product) by a 16-bit divisor into a 16-bit quotient and a 16-bit remainder, resolving one quotient bit per clock.
- Used in the complex-multiplier subsystem for normalisation and scaling of multiplier outputs, and as a self-check partner for the multiplier bench.

## Interface
Parameters:
- none (widths fixed: dividend 32, divisor/quotient/remainder 16)

Ports:
- clk  input  1  single clock; all state changes on its rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  32  dividend; captured on the accepting edge
- b  input  16  divisor; captured on the accepting edge
- q  output  16  quotient; valid while done=1, held until the next accept
- r  output  16  remainder; valid while done=1, held until the next accept
- busy  output  1  high from the accepting edge until the return to IDLE (covers RUN and DONE)
- done  output  1  one-cycle pulse; q/r/err valid
- err  output  1  divide-by-zero or quotient overflow; valid with done, held like q/r

## Operation
- Reset (rst=1 at an edge): state=IDLE; q=0, r=0, busy=0, done=0, err=0; iteration counter=0. Reset wins over every other event, including mid-RUN: the operation aborts silently and no done is generated.
- States: IDLE, RUN, DONE.
- IDLE, start=1, at edge E0:
  - Latch a and b; clear err; busy goes to 1.
  - Check for error: b==0, or a[31:16] >= b (the quotient does not fit in 16 bits).
  - Error: q<=16'hFFFF, r<=16'h0000, err<=1, state<=DONE.
  - Otherwise: partial remainder R<=a[31:16], shift register D<=a[15:0], counter<=15, state<=RUN.
- RUN, each edge:
  - t = {R, D[15]} (17 bits).
  - If t >= {1'b0,b}: R<=t-b (result fits 16 bits) and qbit=1; else R<=t[15:0] and qbit=0.
  - D shifts left and takes qbit into its LSB.
  - Counter decrements.
  - On the edge where the counter is 0: q<=final D, r<=final R, state<=DONE.
- DONE: done=1 for exactly this one cycle; next edge goes to IDLE with busy<=0 and done<=0.
- Width rules: all comparisons are unsigned. The invariant R < b holds throughout RUN, so the subtraction never underflows and the remainder always fits 16 bits.
- start outside IDLE is ignored, including while done=1. a and b may change freely after E0.

## Timing
- Normal latency: 16 iteration edges E1..E16 follow E0; state is DONE and done=1 in the cycle after E16.
- Error latency: done=1 in the cycle after E0.
- Throughput: the earliest next accept is E18 (normal) or E2 (error), because IDLE is re-entered at E17 / E1.
- busy=1 is the gating signal for upstream: drive start only when busy=0.
- q, r and err are unchanged from done until the next accepting edge, which overwrites err (and, on error, q/r) at E0.
- start held high continuously yields back-to-back operations, each on the first IDLE edge.

## Test plan
- a=32'd100, b=16'd7, start pulse at E0 -> done in the cycle after E16; q=16'd14, r=16'd2, err=0; busy high for exactly 17 cycles.
- Multiplier round trip: a=32'hFFFE0001 (16'hFFFF×16'hFFFF), b=16'hFFFF -> q=16'hFFFF, r=16'h0000, err=0.
- Divide by zero: a=32'h12345678, b=0 -> done in the cycle after E0; q=16'hFFFF, r=16'h0000, err=1.
- Overflow: a=32'h00050000, b=16'd5 -> err=1 and done in the cycle after E0. Then boundary a=32'h0004FFFF, b=16'd5 -> q=16'hFFFF, r=16'd4, err=0.
- rst=1 at E8 of a run (a=100, b=7) -> state IDLE, busy=0, q=r=0, no done pulse. A new request (a=32'd65535, b=16'd256) -> q=16'd255, r=16'd255.
- start toggled high during RUN and while done=1 -> ignored, no result change. start held high -> second accept at E18, and its result is correct.
